adder_arbiter: RTL and testbench

- Shares one pipelined `adder` instance between NREQ requesters.
- Each grant is round-robin.
- The arbiter registers and issues the winning operand pair to the adder.
- It tracks the requester ID of every in-flight operation in a tag pipeline matched to the adder latency, and routes each result back to its originator.
- Sits between the requester-side logic and the `adder` DUT in the class-based test environment.

---
 rtl/adder_arbiter_if.sv | 29 ++
 rtl/adder_arbiter.sv | 156 +++++++++++++++
 tb/tb_adder_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/adder_arbiter_if.sv
// Requester-side bus of adder_arbiter.
//   req        per-requester request, held with operands until granted
//   req_a/b    packed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt        one-hot grant (combinational)
//   rsp_valid  one-hot, single-cycle result strobe
//   rsp_result result accompanying rsp_valid
// Modports: master = requester logic, slave = arbiter.
interface adder_arbiter_if #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RES_WIDTH = WIDTH + 1
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       rsp_valid;
    logic [RES_WIDTH-1:0]  rsp_result;

    modport master (
        output req, req_a, req_b,
        input  gnt, rsp_valid, rsp_result
    );

    modport slave (
        input  req, req_a, req_b,
        output gnt, rsp_valid, rsp_result
    );
endinterface

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one pipelined adder between NREQ requesters.
// Round-robin grant, registered issue to the adder, and a tag pipeline
// matched to ADD_LATENCY that routes each result back to its requester.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   en              enable; 0 stops granting and drains in-flight ops
//   rq (slave)      requester bus: req/req_a/req_b in, gnt/rsp_* out
//   add_valid_in, add_a, add_b   issue to adder (registered)
//   add_valid_out, add_result    return from adder
//   idle            registered; IDLE with nothing in flight
//   err             sticky; adder output and tag pipeline disagree
// Optional: define ADDER_ARB_STATS_EN to add issue_cnt / stall_cnt
// saturating 32-bit counters.
module adder_arbiter #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned NREQ        = 4,
    parameter int unsigned ADD_LATENCY = 1,
    parameter int unsigned RES_WIDTH   = WIDTH + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    adder_arbiter_if.slave       rq,
    output logic                 add_valid_in,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    input  logic                 add_valid_out,
    input  logic [RES_WIDTH-1:0] add_result,
    output logic                 idle,
    output logic                 err
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [31:0]          issue_cnt,
    output logic [31:0]          stall_cnt
`endif
);

    localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NSTG = ADD_LATENCY + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
    } tag_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_q;
    tag_t           tag_q [NSTG];
    tag_t           tag_d [NSTG];

    logic           xfer;
    logic [IDW-1:0] gnt_id;
    int unsigned    arb_idx;
    logic           tags_empty_d;
    logic           rsp_hit;
    logic           err_set;

    // Round-robin search starting at rr_q; wraps explicitly at NREQ-1 so
    // non-power-of-two NREQ works.  Granting needs both RUN and en so a
    // falling en blocks the grant in the same cycle.
    always_comb begin
        xfer    = 1'b0;
        gnt_id  = '0;
        arb_idx = 0;
        if (state_q == S_RUN && en) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                arb_idx = 32'(rr_q) + k;
                if (arb_idx >= NREQ) arb_idx = arb_idx - NREQ;
                if (!xfer && rq.req[IDW'(arb_idx)]) begin
                    xfer   = 1'b1;
                    gnt_id = IDW'(arb_idx);
                end
            end
        end
    end

    assign rq.gnt = xfer ? (NREQ'(1) << gnt_id) : '0;

    // Tag pipeline next state: stage 0 captures this cycle's transfer.
    always_comb begin
        tag_d[0].valid = xfer;
        tag_d[0].id    = gnt_id;
        for (int unsigned s = 1; s < NSTG; s++) tag_d[s] = tag_q[s-1];
        tags_empty_d = 1'b1;
        for (int unsigned s = 0; s < NSTG; s++) begin
            if (tag_d[s].valid) tags_empty_d = 1'b0;
        end
    end

    // DRAIN exits on the pipeline contents after this edge, so IDLE is
    // reached in the cycle right after the final result is returned.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en) state_d = S_RUN;
            S_RUN:   if (!en) state_d = S_DRAIN;
            S_DRAIN: begin
                if (en)                state_d = S_RUN;
                else if (tags_empty_d) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Result routing: last tag stage lines up with add_valid_out.
    assign rsp_hit       = add_valid_out && tag_q[NSTG-1].valid;
    assign rq.rsp_valid  = rsp_hit ? (NREQ'(1) << tag_q[NSTG-1].id) : '0;
    assign rq.rsp_result = rsp_hit ? add_result : '0;
    assign err_set       = add_valid_out != tag_q[NSTG-1].valid;

    // State, pointer, issue registers, tags, idle and err.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            rr_q         <= '0;
            add_valid_in <= 1'b0;
            add_a        <= '0;
            add_b        <= '0;
            idle         <= 1'b1;
            err          <= 1'b0;
            for (int unsigned s = 0; s < NSTG; s++) tag_q[s] <= '0;
        end else begin
            state_q      <= state_d;
            add_valid_in <= xfer;
            if (xfer) begin
                rr_q  <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
                add_a <= rq.req_a[32'(gnt_id) * WIDTH +: WIDTH];
                add_b <= rq.req_b[32'(gnt_id) * WIDTH +: WIDTH];
            end
            for (int unsigned s = 0; s < NSTG; s++) tag_q[s] <= tag_d[s];
            idle <= (state_d == S_IDLE) && tags_empty_d;
            if (err_set) err <= 1'b1;
        end
    end

`ifdef ADDER_ARB_STATS_EN
    // Saturating issue / stall counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (xfer && issue_cnt != '1) issue_cnt <= issue_cnt + 32'd1;
            if (state_q == S_RUN && |rq.req && !xfer && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter (WIDTH=8, NREQ=4, ADD_LATENCY=1) with a
// one-cycle behavioural adder that shares the arbiter reset.
module tb_adder_arbiter;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned RW    = WIDTH + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          add_valid_in;
    logic [WIDTH-1:0] add_a, add_b;
    logic          add_valid_out;
    logic [RW-1:0] add_result;
    logic          idle, err;
    logic          force_vo;
    logic          vo_q;
    logic [RW-1:0] res_q;
`ifdef ADDER_ARB_STATS_EN
    logic [31:0]   issue_cnt, stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] seq3 [3];

    adder_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .RES_WIDTH(RW)) bus ();

    adder_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .ADD_LATENCY(1), .RES_WIDTH(RW)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .rq            (bus),
        .add_valid_in  (add_valid_in),
        .add_a         (add_a),
        .add_b         (add_b),
        .add_valid_out (add_valid_out),
        .add_result    (add_result),
        .idle          (idle),
        .err           (err)
`ifdef ADDER_ARB_STATS_EN
        ,
        .issue_cnt     (issue_cnt),
        .stall_cnt     (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in adder with latency 1; force_vo injects a spurious valid.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            vo_q  <= 1'b0;
            res_q <= '0;
        end else begin
            vo_q  <= add_valid_in;
            res_q <= RW'(add_a) + RW'(add_b);
        end
    end
    assign add_valid_out = vo_q | force_vo;
    assign add_result    = res_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        bus.req_a[i*8 +: 8] = a;
        bus.req_b[i*8 +: 8] = b;
    endtask

    // Reset arbiter and adder together, then enable (RUN at the next edge).
    task automatic start_run();
        nxt();
        rst = 1'b0; bus.req = '0; en = 1'b0; force_vo = 1'b0;
        nxt();
        rst = 1'b1; en = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        seq3[0] = 4'b0010; seq3[1] = 4'b1000; seq3[2] = 4'b0010;
        rst = 1'b0; en = 1'b0; force_vo = 1'b0;
        bus.req = '0; bus.req_a = '0; bus.req_b = '0;

        // Reset values
        smp();
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_result", 32'(bus.rsp_result), 0);
        chk("rst_add_valid_in", 32'(add_valid_in), 0);
        chk("rst_add_a", 32'(add_a), 0);
        chk("rst_idle", 32'(idle), 1);
        chk("rst_err", 32'(err), 0);

        // Single requester: 3 + 4
        start_run();
        nxt(); bus.req = 4'b0001; set_ops(0, 8'd3, 8'd4); smp();
        chk("t1_gnt", 32'(bus.gnt), 1);
        nxt(); bus.req = 4'b0000; smp();
        chk("t1_add_valid_in", 32'(add_valid_in), 1);
        chk("t1_add_a", 32'(add_a), 3);
        chk("t1_add_b", 32'(add_b), 4);
        chk("t1_idle", 32'(idle), 0);
        nxt(); smp();
        chk("t1_rsp_valid", 32'(bus.rsp_valid), 1);
        chk("t1_rsp_result", 32'(bus.rsp_result), 7);
        chk("t1_add_valid_in_low", 32'(add_valid_in), 0);

        // All four requesting: a=i, b=10
        start_run();
        for (int i = 0; i < 4; i++) set_ops(i, 8'(i), 8'd10);
        for (int c = 0; c < 10; c++) begin
            nxt(); bus.req = (c < 8) ? 4'hF : 4'h0; smp();
            chk("t2_gnt", 32'(bus.gnt), (c < 8) ? (32'd1 << (c % 4)) : 0);
            if (c >= 2) begin
                chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'd1 << ((c - 2) % 4));
                chk("t2_rsp_result", 32'(bus.rsp_result), 32'(10 + (c - 2) % 4));
            end
        end

        // Requesters 1 and 3 only: 1, 3, 1
        start_run();
        for (int c = 0; c < 5; c++) begin
            nxt(); bus.req = (c < 3) ? 4'b1010 : 4'b0000; smp();
            chk("t3_gnt", 32'(bus.gnt), (c < 3) ? 32'(seq3[c]) : 0);
            if (c >= 2) begin
                chk("t3_rsp_valid", 32'(bus.rsp_valid), 32'(seq3[c-2]));
                chk("t3_rsp_result", 32'(bus.rsp_result), (seq3[c-2] == 4'b1000) ? 13 : 11);
            end
        end
        chk("t3_err", 32'(err), 0);

        // en dropped with two ops in flight, alongside a new request
        start_run();
        set_ops(0, 8'd20, 8'd1); set_ops(1, 8'd30, 8'd2);
        nxt(); bus.req = 4'b0011; smp();
        chk("t4_gnt0", 32'(bus.gnt), 32'b0001);
        nxt(); bus.req = 4'b0010; smp();
        chk("t4_gnt1", 32'(bus.gnt), 32'b0010);
        nxt(); bus.req = 4'b0100; en = 1'b0; smp();
        chk("t4_gnt_en_fall", 32'(bus.gnt), 0);
        chk("t4_rsp0_valid", 32'(bus.rsp_valid), 32'b0001);
        chk("t4_rsp0_result", 32'(bus.rsp_result), 21);
        chk("t4_idle_c2", 32'(idle), 0);
        nxt(); smp();
        chk("t4_gnt_drain", 32'(bus.gnt), 0);
        chk("t4_rsp1_valid", 32'(bus.rsp_valid), 32'b0010);
        chk("t4_rsp1_result", 32'(bus.rsp_result), 32);
        chk("t4_idle_c3", 32'(idle), 0);
        nxt(); smp();
        chk("t4_idle_c4", 32'(idle), 1);
        chk("t4_rsp_none", 32'(bus.rsp_valid), 0);
        chk("t4_gnt_idle", 32'(bus.gnt), 0);
        chk("t4_err", 32'(err), 0);
        bus.req = '0;

        // Spurious adder output raises sticky err; reset clears it
        nxt(); force_vo = 1'b1; smp();
        chk("t5_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("t5_err_before", 32'(err), 0);
        nxt(); force_vo = 1'b0; smp();
        chk("t5_err_set", 32'(err), 1);
        nxt(); smp();
        chk("t5_err_sticky", 32'(err), 1);
        rst = 1'b0; #1;
        chk("t5_err_cleared", 32'(err), 0);
        chk("t5_idle_reset", 32'(idle), 1);

        // Overflow: 255 + 255 = 510
        start_run();
        nxt(); bus.req = 4'b0001; set_ops(0, 8'd255, 8'd255); smp();
        chk("t6_gnt", 32'(bus.gnt), 1);
        nxt(); bus.req = 4'b0000; smp();
        nxt(); smp();
        chk("t6_rsp_valid", 32'(bus.rsp_valid), 1);
        chk("t6_rsp_result", 32'(bus.rsp_result), 510);
`ifdef ADDER_ARB_STATS_EN
        chk("t6_issue_cnt", issue_cnt, 1);
        chk("t6_stall_cnt", stall_cnt, 0);
`endif
        chk("t6_err", 32'(err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
